// File: rtl/coffee_pkg.sv
// Shared types for the coffee brew scheduler: brew states,
// dispenser indices and the step sequencing helpers.
package coffee_pkg;

   localparam int NUM_DISP = 5;

   localparam logic [2:0] DISP_CUP    = 3'd0;
   localparam logic [2:0] DISP_WATER  = 3'd1;
   localparam logic [2:0] DISP_MILK   = 3'd2;
   localparam logic [2:0] DISP_COFFEE = 3'd3;
   localparam logic [2:0] DISP_SUGAR  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CUP,
      S_WATER,
      S_MILK,
      S_COFFEE,
      S_SUGAR,
      S_DONE,
      S_ABORT
   } brew_state_t;

   function automatic logic [2:0] step_disp(input brew_state_t s);
      unique case (s)
         S_CUP:    return DISP_CUP;
         S_WATER:  return DISP_WATER;
         S_MILK:   return DISP_MILK;
         S_COFFEE: return DISP_COFFEE;
         S_SUGAR:  return DISP_SUGAR;
         default:  return DISP_CUP;
      endcase
   endfunction

   function automatic brew_state_t next_step(input brew_state_t s,
                                             input logic sugar);
      unique case (s)
         S_CUP:    return S_WATER;
         S_WATER:  return S_MILK;
         S_MILK:   return S_COFFEE;
         S_COFFEE: return sugar ? S_SUGAR : S_DONE;
         default:  return S_DONE;
      endcase
   endfunction

endpackage

// File: rtl/coffee_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer,
// scanning upward with wrap. Purely combinational.
module coffee_rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [PW-1:0]      win_idx,
   output logic               win_any
);

   always_comb begin
      win     = '0;
      win_idx = '0;
      win_any = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!win_any && req[(int'(ptr) + i) % NUM_REQ]) begin
            win_any = 1'b1;
            win_idx = PW'((int'(ptr) + i) % NUM_REQ);
            win[(int'(ptr) + i) % NUM_REQ] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/coffee_brew_scheduler.sv
// Shares one brew unit between order panels; stock tracked per dispenser.
// COFFEE_CUP_COUNT_EN adds cups_served / faults_seen counters.
module coffee_brew_scheduler
   import coffee_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int STEP_CYCLES = 8,
   parameter int STOCK_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  req,
   input  logic [NUM_REQ-1:0]  want_sugar,
   input  logic [NUM_DISP-1:0] refill,
   output logic [NUM_REQ-1:0]  grant,
   output logic [NUM_DISP-1:0] disp_en,
   output logic                coffee_ready,
   output logic                fault,
   output logic [2:0]          fault_code,
   output logic                busy,
   output logic [NUM_DISP-1:0] stock_empty
`ifdef COFFEE_CUP_COUNT_EN
   ,
   output logic [15:0]         cups_served,
   output logic [7:0]          faults_seen
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TW = $clog2(STEP_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(STEP_CYCLES - 1);
   localparam logic [STOCK_W-1:0] S_MAX = '1;

   brew_state_t state, state_d;
   logic [TW-1:0] timer, timer_d;
   logic [PW-1:0] ptr;
   logic [NUM_REQ-1:0] win;
   logic [PW-1:0] win_idx;
   logic win_any;
   logic sugar;
   logic [2:0] cur, fail_idx;
   logic [NUM_DISP-1:0][STOCK_W-1:0] stock;
   logic [NUM_DISP-1:0] dec, en_d;
   logic ready_d, fault_d, abort_d;

   coffee_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PW      (PW)
   ) u_arb (
      .req     (req),
      .ptr     (ptr),
      .win     (win),
      .win_idx (win_idx),
      .win_any (win_any)
   );

   assign cur  = step_disp(state);
   assign busy = |grant;

   // Outputs are registered, so enables trail the step's state by one cycle.
   always_comb begin
      state_d = state;
      timer_d = timer;
      dec     = '0;
      en_d    = '0;
      ready_d = 1'b0;
      fault_d = 1'b0;
      abort_d = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (win_any) begin
               state_d = S_CUP;
               timer_d = '0;
            end
         end
         S_CUP, S_WATER, S_MILK, S_COFFEE, S_SUGAR: begin
            if (timer == '0 && stock[cur] == '0 && !refill[cur]) begin
               state_d = S_ABORT;
               abort_d = 1'b1;
            end else begin
               en_d[cur] = 1'b1;
               if (timer == '0) dec[cur] = 1'b1;
               if (timer == T_LAST) begin
                  timer_d = '0;
                  state_d = next_step(state, sugar);
               end else begin
                  timer_d = timer + 1'b1;
               end
            end
         end
         S_DONE: begin
            ready_d = 1'b1;
            state_d = S_IDLE;
         end
         S_ABORT: begin
            fault_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         timer        <= '0;
         ptr          <= '0;
         sugar        <= 1'b0;
         grant        <= '0;
         disp_en      <= '0;
         coffee_ready <= 1'b0;
         fault        <= 1'b0;
         fault_code   <= '0;
         fail_idx     <= '0;
      end else begin
         state        <= state_d;
         timer        <= timer_d;
         disp_en      <= en_d;
         coffee_ready <= ready_d;
         fault        <= fault_d;
         if (abort_d) fail_idx <= cur;
         if (fault_d) fault_code <= fail_idx;
         if (state == S_IDLE) begin
            grant <= win;
            if (win_any) begin
               sugar <= want_sugar[win_idx];
               ptr   <= (win_idx == PW'(NUM_REQ - 1)) ? '0
                                                      : win_idx + 1'b1;
            end
         end
      end
   end

   // Refill and consume in one cycle cancel out.
   always_ff @(posedge clk) begin
      for (int d = 0; d < NUM_DISP; d++) begin
         if (rst) begin
            stock[d] <= '0;
         end else if (refill[d] && !dec[d]) begin
            if (stock[d] != S_MAX) stock[d] <= stock[d] + 1'b1;
         end else if (dec[d] && !refill[d]) begin
            stock[d] <= stock[d] - 1'b1;
         end
      end
   end

   always_comb begin
      stock_empty = '0;
      for (int d = 0; d < NUM_DISP; d++) begin
         stock_empty[d] = (stock[d] == '0);
      end
   end

`ifdef COFFEE_CUP_COUNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cups_served <= '0;
         faults_seen <= '0;
      end else begin
         if (coffee_ready) cups_served <= cups_served + 16'd1;
         if (fault && faults_seen != 8'hFF)
            faults_seen <= faults_seen + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_coffee_brew_scheduler.sv
// Scoreboard bench for coffee_brew_scheduler: stimulus queues expected
// grant/ready/fault events, a negedge monitor pops and compares them.
module tb_coffee_brew_scheduler;

   localparam int K_GRANT = 0;
   localparam int K_READY = 1;
   localparam int K_FAULT = 2;

   typedef struct {
      int               kind;
      logic [3:0]       gnt;
      int               lat;
      logic [2:0]       code;
      logic [4:0][7:0]  en;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [3:0] want_sugar;
   logic [4:0] refill;
   logic [3:0] grant;
   logic [4:0] disp_en;
   logic       coffee_ready;
   logic       fault;
   logic [2:0] fault_code;
   logic       busy;
   logic [4:0] stock_empty;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   int cyc    = 0;
   exp_t q[$];

   coffee_brew_scheduler #(
      .NUM_REQ     (4),
      .STEP_CYCLES (8),
      .STOCK_W     (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .want_sugar   (want_sugar),
      .refill       (refill),
      .grant        (grant),
      .disp_en      (disp_en),
      .coffee_ready (coffee_ready),
      .fault        (fault),
      .fault_code   (fault_code),
      .busy         (busy),
      .stock_empty  (stock_empty)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] want);
      checks++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)",
                  name, act, want, cyc);
      end else begin
         passes++;
      end
   endtask

   task automatic push_grant(input logic [3:0] g);
      exp_t e;
      e.kind = K_GRANT; e.gnt = g; e.lat = 0; e.code = '0; e.en = '0;
      q.push_back(e);
   endtask

   task automatic push_end(input int k, input int lat,
                           input logic [2:0] code,
                           input logic [39:0] en);
      exp_t e;
      e.kind = k; e.gnt = '0; e.lat = lat; e.code = code; e.en = en;
      q.push_back(e);
   endtask

   // Monitor: one comparison per DUT event, plus per-cycle enable sanity.
   logic [3:0]      prev_grant = '0;
   logic [4:0][7:0] cnt = '0;
   int              gcyc = 0;

   always @(negedge clk) begin
      exp_t e;
      chk("disp_en_onehot0", 64'($countones(disp_en) <= 1), 64'd1);
      if (grant != 4'd0 && grant != prev_grant) begin
         gcyc = cyc;
         cnt  = '0;
         if (q.size() == 0) begin
            chk("unexpected_grant", 64'(grant), 64'd0);
         end else begin
            e = q.pop_front();
            chk("grant_kind", 64'(e.kind), 64'(K_GRANT));
            chk("grant_value", 64'(grant), 64'(e.gnt));
         end
      end
      for (int d = 0; d < 5; d++) if (disp_en[d]) cnt[d] = cnt[d] + 8'd1;
      if (coffee_ready || fault) begin
         if (q.size() == 0) begin
            chk("unexpected_done", 64'({coffee_ready, fault}), 64'd0);
         end else begin
            e = q.pop_front();
            chk("done_kind", 64'(fault ? K_FAULT : K_READY), 64'(e.kind));
            chk("done_latency", 64'(cyc - gcyc), 64'(e.lat));
            chk("enable_cycles", 64'(cnt), 64'(e.en));
            if (fault) chk("fault_code", 64'(fault_code), 64'(e.code));
         end
      end
      prev_grant = grant;
   end

   task automatic do_refill(input logic [4:0] m, input int n);
      repeat (n) begin
         refill = m;
         @(negedge clk);
      end
      refill = '0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(coffee_ready || fault) && n < budget);
      chk("done_timeout", 64'(coffee_ready | fault), 64'd1);
   endtask

   task automatic wait_grant(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (grant == 4'd0 && n < budget);
      chk("grant_timeout", 64'(grant != 4'd0), 64'd1);
   endtask

   logic [3:0] ord [3];

   initial begin
      rst = 1'b1; req = '0; want_sugar = '0; refill = '0;
      ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b1000;
      repeat (3) @(negedge clk);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_disp_en", 64'(disp_en), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_ready", 64'(coffee_ready), 64'd0);
      chk("rst_fault", 64'(fault), 64'd0);
      chk("rst_fault_code", 64'(fault_code), 64'd0);
      chk("rst_stock_empty", 64'(stock_empty), 64'h1f);
      rst = 1'b0;

      do_refill(5'h1f, 3);
      chk("refill_stock_empty", 64'(stock_empty), 64'h0);

      // Single brew with sugar
      push_grant(4'b0001);
      push_end(K_READY, 41, 3'd0, 40'h08_08_08_08_08);
      req = 4'b0001; want_sugar = 4'b0001;
      wait_done(200);
      req = '0; want_sugar = '0;
      @(negedge clk);
      chk("busy_after_ready", 64'(busy), 64'd0);
      chk("grant_after_ready", 64'(grant), 64'd0);
      chk("stock_after_sugar", 64'(stock_empty), 64'h0);

      // No sugar
      push_grant(4'b0001);
      push_end(K_READY, 33, 3'd0, 40'h00_08_08_08_08);
      req = 4'b0001;
      wait_done(200);
      req = '0;
      @(negedge clk);
      chk("stock_after_nosugar", 64'(stock_empty), 64'h0);

      // Refill on the COFFEE entry cycle with coffee stock at 1
      push_grant(4'b0001);
      push_end(K_READY, 33, 3'd0, 40'h00_08_08_08_08);
      req = 4'b0001;
      wait_grant(20);
      repeat (24) @(negedge clk);
      refill = 5'b01000;
      @(negedge clk);
      refill = '0;
      wait_done(200);
      req = '0;
      @(negedge clk);
      chk("stock_after_collision", 64'(stock_empty), 64'h07);

      // Empty milk dispenser
      do_refill(5'b11011, 1);
      push_grant(4'b0001);
      push_end(K_FAULT, 18, 3'd2, 40'h00_00_00_08_08);
      req = 4'b0001;
      wait_done(200);
      req = '0;
      @(negedge clk);
      chk("busy_after_fault", 64'(busy), 64'd0);
      chk("grant_after_fault", 64'(grant), 64'd0);
      chk("fault_code_held", 64'(fault_code), 64'd2);
      chk("stock_after_fault", 64'(stock_empty), 64'h07);

      // Round-robin from a fresh pointer
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      do_refill(5'h1f, 10);
      for (int i = 0; i < 3; i++) begin
         push_grant(ord[i]);
         push_end(K_READY, 33, 3'd0, 40'h00_08_08_08_08);
      end
      req = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         wait_done(200);
         req = req & ~ord[i];
      end
      @(negedge clk);
      chk("busy_after_rr", 64'(busy), 64'd0);

      // Reset during WATER
      push_grant(4'b0001);
      req = 4'b0001;
      wait_grant(20);
      repeat (10) @(negedge clk);
      chk("water_active", 64'(disp_en), 64'h02);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_disp_en", 64'(disp_en), 64'd0);
      chk("midrst_grant", 64'(grant), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_ready", 64'(coffee_ready), 64'd0);
      chk("midrst_fault", 64'(fault), 64'd0);
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_stock_empty", 64'(stock_empty), 64'h1f);
      repeat (60) @(negedge clk);

      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
